return_stack: RTL
=================

RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 The block SHALL have parameter WIDTH, default 9, the width of one stored return address, equal to the program counter width.
REQ-002 The block SHALL have parameter DEPTH, default 8, the number of stack entries; DEPTH SHALL be a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, the reset; it is synchronous and active-high.
REQ-005 The block SHALL have port push, input, 1 bit, a request to store push_data as the new top of stack.
REQ-006 The block SHALL have port pop, input, 1 bit, a request to discard the current top of stack.
REQ-007 The block SHALL have port push_data, input, WIDTH bits, the return address to store, normally PC+1 at CALL.
REQ-008 The block SHALL have port clear_err, input, 1 bit, which clears the sticky error flags.
REQ-009 The block SHALL have port top, output, WIDTH bits, the current top-of-stack value, used as the counter load value at RET.
REQ-010 The block SHALL have port empty, output, 1 bit, high when no entries are held.
REQ-011 The block SHALL have port full, output, 1 bit, high when DEPTH entries are held.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH)+1 bits, the number of entries held.
REQ-013 The block SHALL have port overflow, output, 1 bit, a sticky flag for a push that was dropped.
REQ-014 The block SHALL have port underflow, output, 1 bit, a sticky flag for a pop on an empty stack.

Function
REQ-015 The block SHALL hold DEPTH registered entries mem[0..DEPTH-1] and a pointer sp in the range 0..DEPTH, where sp equals count.
REQ-016 The block SHALL decode outputs as empty = (sp==0), full = (sp==DEPTH), top = mem[sp-1] when not empty and 0 when empty, with no added pipeline register.
REQ-017 The block SHALL perform a push when push=1, pop=0 and not full: mem[sp] <= push_data and sp <= sp+1, so the new value appears on top in the next cycle.
REQ-018 The block SHALL perform a pop when pop=1, push=0 and not empty: sp <= sp-1 with mem unchanged, so the previous entry appears on top in the next cycle.
REQ-019 The block SHALL perform a replace when push=1, pop=1 and not empty: mem[sp-1] <= push_data with sp unchanged; this also applies when full, and overflow SHALL NOT be set.
REQ-020 The block SHALL treat push=1, pop=1 when empty as a plain push, with underflow NOT set.
REQ-021 The block SHALL ignore a push (push=1, pop=0) when full, leaving mem and sp unchanged, and SHALL set overflow to 1.
REQ-022 The block SHALL ignore a pop (pop=1, push=0) when empty, leaving sp at 0, and SHALL set underflow to 1.
REQ-023 The block SHALL hold overflow and underflow at 1 until reset or clear_err.
REQ-024 When clear_err=1, the block SHALL clear both flags that cycle; an error event in the same cycle SHALL win and set its flag.
REQ-025 The block SHALL NOT wrap sp in either direction; counting saturates at 0 and DEPTH.
REQ-026 The block SHALL have a latency of one clock from request to the updated top/count/empty/full, with no stall or busy state, so that back-to-back operations are accepted every cycle.

Reset
REQ-027 When reset=1 at a rising clk edge, the block SHALL set sp=0, overflow=0 and underflow=0, and hence empty=1, full=0, count=0, top=0.
REQ-028 Reset SHALL take priority over push, pop and clear_err in the same cycle; any in-progress sequence is abandoned.
REQ-029 The block SHALL NOT clear mem contents on reset; they are unobservable while empty.
REQ-030 After power-up and before the first reset, the block SHALL report sp=0 (initial value 0).

Verification
REQ-031 A bench SHALL cover: reset, then push 0x012, push 0x034, pop -> top=0x034 after the 2nd push, top=0x012 after the pop, count=1.
REQ-032 A bench SHALL cover: 8 pushes of 0x100..0x107, then a 9th push of 0x1FF -> full=1, count=8, top=0x107, overflow=1.
REQ-033 A bench SHALL cover: pop on empty after reset -> empty=1, count=0, top=0, underflow=1; then clear_err=1 for one cycle -> underflow=0.
REQ-034 A bench SHALL cover: stack holding 0x010, 0x020, then push=pop=1 with 0x0AA -> count=2, top=0x0AA; a following pop -> top=0x010.
REQ-035 A bench SHALL cover: with the stack full, push=pop=1 with 0x055 -> count=8, top=0x055, overflow stays 0.
REQ-036 A bench SHALL cover: 3 entries pushed and overflow set, then reset asserted together with push=1 -> next cycle count=0, empty=1, top=0, overflow=0.

Source files
------------

// File: rtl/return_stack.sv
// Return-address stack for a small sequencer.
// CALL pushes PC+1, RET reads `top` as the counter load value and pops.
// Entries are plain registers so `top` is a combinational read of the
// current top slot with no extra pipeline stage. A push and a pop in the
// same cycle overwrite the top entry in place ("replace"). Pushing onto a
// full stack and popping an empty stack are both dropped and raise sticky
// error flags.
module return_stack #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8   // power of two, at least 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     clear_err,
  output logic [WIDTH-1:0]         top,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  // Stack pointer: the number of entries held, 0..DEPTH.
  // The initialiser gives sp = 0 at power-up, before the first reset.
  logic [CW-1:0]    sp_reg = '0;
  logic [CW-1:0]    sp_next;
  logic             overflow_reg = 1'b0;
  logic             underflow_reg = 1'b0;

  // Decoded operation for this cycle.
  logic             empty_w;
  logic             full_w;
  logic             do_push;
  logic             do_pop;
  logic             do_replace;
  logic             overflow_evt;
  logic             underflow_evt;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] mem [DEPTH];

  // Classify the request against the current occupancy.
  always_comb begin
    empty_w       = (sp_reg == '0);
    full_w        = (sp_reg == DEPTH_CNT);
    // A push+pop on an empty stack has nothing to replace, so it acts
    // as a plain push. Empty implies not full because DEPTH >= 2.
    do_replace    = push & pop & ~empty_w;
    do_push       = push & ~full_w & (~pop | empty_w);
    do_pop        = pop & ~push & ~empty_w;
    overflow_evt  = push & ~pop & full_w;
    underflow_evt = pop & ~push & empty_w;

    // The index of the top entry is (sp - 1) mod DEPTH. Using only the
    // low bits of sp also covers sp == DEPTH, where those bits are zero.
    top_idx = sp_reg[AW-1:0] - AW'(1);

    // A push writes the free slot at sp; a replace overwrites the top.
    wr_en  = do_push | do_replace;
    wr_idx = do_replace ? top_idx : sp_reg[AW-1:0];

    // The pointer saturates at 0 and DEPTH, because the dropped cases
    // never assert do_push or do_pop.
    sp_next = sp_reg;
    if (do_push) begin
      sp_next = sp_reg + CW'(1);
    end else if (do_pop) begin
      sp_next = sp_reg - CW'(1);
    end
  end

  // Advance the stack pointer. Reset empties the stack.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_reg <= '0;
    end else begin
      sp_reg <= sp_next;
    end
  end

  // Sticky error flags. An error event in the same cycle as clear_err
  // wins, so the flag stays set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= overflow_evt  | (overflow_reg  & ~clear_err);
      underflow_reg <= underflow_evt | (underflow_reg & ~clear_err);
    end
  end

  // One register per stack slot. Reset does not clear the contents,
  // because no slot is visible while the stack is empty.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_reg;

    // Capture push_data when this slot is the write target.
    always_ff @(posedge clk) begin
      if (wr_en && (wr_idx == AW'(gi))) begin
        entry_reg <= push_data;
      end
    end

    assign mem[gi] = entry_reg;
  end

  // Output decode. top reads as zero while the stack is empty, so stale
  // slot contents never leak out after reset or a full unwind.
  always_comb begin
    empty     = empty_w;
    full      = full_w;
    count     = sp_reg;
    top       = empty_w ? '0 : mem[top_idx];
    overflow  = overflow_reg;
    underflow = underflow_reg;
  end

endmodule
